wof_eval_arbiter: RTL

//   Shares one instance of the 4-input "wof" gate function among NREQ requesters.

---
 rtl/wof_pkg.sv | 21 ++
 rtl/wof_rr_pick.sv | 39 +++
 rtl/wof_eval_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/wof_pkg.sv
// Shared types and the gate function for the wof evaluation arbiter.
package wof_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  // Operand order: bit3=one, bit2=two, bit1=three, bit0=four.
  function automatic logic wof_eval(input logic [3:0] op);
    logic one, two, three, four, five;
    one   = op[3];
    two   = op[2];
    three = op[1];
    four  = op[0];
    five  = two | three | four;
    return ~((one & two & five) | ~five);
  endfunction

endpackage

// File: rtl/wof_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module wof_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_id,
  output logic            any
);

  logic [NREQ-1:0] rot;
  logic [IDW-1:0]  rot_idx [NREQ];

  // rot[k] is the request k positions after rr_ptr, so rot[0] has top priority.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    logic [IDW:0] sum;
    assign sum         = {1'b0, rr_ptr} + (IDW+1)'(gi);
    assign rot_idx[gi] = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : sum[IDW-1:0];
    assign rot[gi]     = req[rot_idx[gi]];
  end

  always_comb begin
    any    = 1'b0;
    gnt_id = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any    = 1'b1;
        gnt_id = rot_idx[k];
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
    assign gnt_onehot[gi] = any && (gnt_id == IDW'(gi));
  end

endmodule

// File: rtl/wof_eval_arbiter.sv
// Round-robin arbiter sharing one wof gate among NREQ requesters, with a tagged valid/ready result.
module wof_eval_arbiter
  import wof_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int CNTW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] op_flat,
  output logic [NREQ-1:0]   ack,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_data,
  output logic              busy,
  output logic [CNTW-1:0]   eval_cnt
);

  state_t          state_reg, state_next;
  logic [NREQ-1:0] ack_reg, ack_next;
  logic            rsp_valid_reg, rsp_valid_next;
  logic [IDW-1:0]  rsp_id_reg, rsp_id_next;
  logic            rsp_data_reg, rsp_data_next;
  logic            busy_reg, busy_next;
  logic [CNTW-1:0] eval_cnt_reg, eval_cnt_next;
  logic [IDW-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [3:0]      op_reg, op_next;

  logic [NREQ-1:0] gnt_onehot;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_any;
  logic [3:0]      op_arr [NREQ];
  logic [IDW:0]    ptr_inc;
  logic [IDW-1:0]  ptr_wrap;

  wof_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req        (req),
    .rr_ptr     (rr_ptr_reg),
    .gnt_onehot (gnt_onehot),
    .gnt_id     (gnt_id),
    .any        (gnt_any)
  );

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_op
    assign op_arr[gi] = op_flat[4*gi +: 4];
  end

  assign ptr_inc  = {1'b0, gnt_id} + 1'b1;
  assign ptr_wrap = (ptr_inc == (IDW+1)'(NREQ)) ? '0 : ptr_inc[IDW-1:0];

  always_comb begin
    state_next     = state_reg;
    ack_next       = '0;
    rsp_valid_next = rsp_valid_reg;
    rsp_id_next    = rsp_id_reg;
    rsp_data_next  = rsp_data_reg;
    eval_cnt_next  = eval_cnt_reg;
    rr_ptr_next    = rr_ptr_reg;
    op_next        = op_reg;
    case (state_reg)
      IDLE: begin
        if (gnt_any) begin
          op_next     = op_arr[gnt_id];
          rsp_id_next = gnt_id;
          ack_next    = gnt_onehot;
          rr_ptr_next = ptr_wrap;
          state_next  = EVAL;
        end
      end
      EVAL: begin
        rsp_data_next  = wof_eval(op_reg);
        rsp_valid_next = 1'b1;
        state_next     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          if (eval_cnt_reg != '1) eval_cnt_next = eval_cnt_reg + 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ack_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_data_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      eval_cnt_reg  <= '0;
      rr_ptr_reg    <= '0;
      op_reg        <= '0;
    end else begin
      state_reg     <= state_next;
      ack_reg       <= ack_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_id_reg    <= rsp_id_next;
      rsp_data_reg  <= rsp_data_next;
      busy_reg      <= busy_next;
      eval_cnt_reg  <= eval_cnt_next;
      rr_ptr_reg    <= rr_ptr_next;
      op_reg        <= op_next;
    end
  end

  assign ack       = ack_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_data  = rsp_data_reg;
  assign busy      = busy_reg;
  assign eval_cnt  = eval_cnt_reg;

endmodule
